mips_mc_control: RTL and testbench
==================================

Name: mips_mc_control

Overview:
- Multicycle control unit for MIPS_new: decodes the latched instruction's opcode/funct and sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Drives every datapath enable and mux select (PC, IR, memory, register file, ALU) and reports the current state on count_state for bench tracing.
- Sits directly upstream of the datapath; one instruction at a time, Moore outputs only.

Parameters:
- STATE_WIDTH, 4, width of count_state / state register.
- ALUOP_WIDTH, 4, width of alu_op code.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, combinational from current ALU operands.
- pc_write  out  1  unconditional PC load.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  write-register select: 0=rt, 1=rd.
- mem_to_reg  out  1  write-data select: 0=ALUOut, 1=memory data.
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  0=PC, 1=RegA, 2=shamt zero-extended.
- alu_src_b  out  3  0=RegB, 1=const 4, 2=sign-ext imm, 3=zero-ext imm, 4=sign-ext imm<<2.
- alu_op  out  ALUOP_WIDTH  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL, 6 SRL, 7 LUI (B<<16).
- alu_out_we  out  1  ALUOut register load.
- pc_src  out  2  0=ALU result, 1=ALUOut, 2=jump target {PC[31:28],IR[25:0],2'b00}.
- illegal_op  out  1  one-cycle pulse in DECODE on unsupported opcode/funct.
- count_state  out  STATE_WIDTH  encoded current state.

Behaviour:
- States/encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, ST_DUMMY=5.
- Reset low: state=IDLE immediately; all outputs 0. IDLE -> FETCH unconditionally on next edge after reset release.
- FETCH: ir_write=1, pc_write=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0. -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=4, alu_op=ADD, alu_out_we=1 (branch target). Supported -> EXEC; unsupported -> illegal_op=1, -> FETCH (no register/memory write).
- Supported: R-type (opcode 0) funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x00 sll, 0x02 srl; addi 0x08, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
- EXEC, R-type: alu_src_a=1 (2 for sll/srl), alu_src_b=0, alu_op per funct, alu_out_we=1. -> WB.
- EXEC, addi/lw/sw: alu_src_a=1, alu_src_b=2, ADD, alu_out_we=1; andi/ori: alu_src_b=3, AND/OR; lui: alu_src_b=3, LUI. -> WB.
- EXEC, beq/bne: alu_src_a=1, alu_src_b=0, SUB, alu_out_we=0, pc_src=1; pc_write = zero (beq) or !zero (bne), same cycle. -> WB.
- WB: R-type reg_write=1, reg_dst=1; I-type ALU reg_write=1, reg_dst=0; lw: iord=1, mem_to_reg=1, reg_write=1, reg_dst=0; sw: iord=1, mem_write=1 -> ST_DUMMY; branch: no strobes. All others -> FETCH.
- ST_DUMMY: iord=1, all strobes 0 (memory write settle). -> FETCH.
- Latencies: ALU/lui/branch/lw 4 cycles (FETCH..WB), sw 5.
- opcode/funct sampled combinationally each state (IR stable after FETCH). Outputs not listed for a state are 0.
- Reset mid-instruction: abandon immediately; no partial strobe may remain asserted.

Optional Feature:
- MIPS_CTRL_JUMP_EN: defined -> j (0x02) supported: DECODE -> EXEC; EXEC pc_write=1, pc_src=2, -> FETCH (3 cycles). Undefined -> 0x02 treated as illegal (illegal_op pulse, no PC change).

Test Plan:
- Reset low 10 ns then high, opcode=0x08 (21080003) -> count_state 0,1,2,3,4,1; reg_write=1 only in state 4 with reg_dst=0, mem_to_reg=0.
- R-type add 01288820 -> EXEC alu_op=0, alu_src_b=0; WB reg_write=1, reg_dst=1; sll 00118880 -> EXEC alu_src_a=2, alu_op=5.
- sw ad910000 -> states 1,2,3,4,5,1; mem_write=1 only in state 4 with iord=1; alu_src_b=2 in state 3.
- lw 8d940000 -> states 1,2,3,4; state 4 iord=1, mem_to_reg=1, reg_write=1.
- beq 11090002: zero=1 in EXEC -> pc_write=1, pc_src=1; zero=0 -> pc_write=0; bne inverse.
- opcode 0x3F -> illegal_op=1 for one cycle in state 2, next state 1, no writes; reset low during state 3 -> count_state=0 and all outputs 0 without waiting for clk.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/EXEC/WB(/ST_DUMMY)
// and drives every datapath enable and mux select from the current state.
// Optional build macro: MIPS_CTRL_JUMP_EN adds the j (opcode 0x02) instruction;
// without it, opcode 0x02 is decoded as illegal.
module mips_mc_control #(
    parameter int STATE_WIDTH = 4,
    parameter int ALUOP_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    input  logic                   zero,
    output logic                   pc_write,
    output logic                   iord,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   reg_write,
    output logic [1:0]             alu_src_a,
    output logic [2:0]             alu_src_b,
    output logic [ALUOP_WIDTH-1:0] alu_op,
    output logic                   alu_out_we,
    output logic [1:0]             pc_src,
    output logic                   illegal_op,
    output logic [STATE_WIDTH-1:0] count_state
);

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE     = STATE_WIDTH'(0),
        FETCH    = STATE_WIDTH'(1),
        DECODE   = STATE_WIDTH'(2),
        EXEC     = STATE_WIDTH'(3),
        WB       = STATE_WIDTH'(4),
        ST_DUMMY = STATE_WIDTH'(5)
    } state_t;

    localparam logic [ALUOP_WIDTH-1:0] OP_ADD = ALUOP_WIDTH'(0);
    localparam logic [ALUOP_WIDTH-1:0] OP_SUB = ALUOP_WIDTH'(1);
    localparam logic [ALUOP_WIDTH-1:0] OP_AND = ALUOP_WIDTH'(2);
    localparam logic [ALUOP_WIDTH-1:0] OP_OR  = ALUOP_WIDTH'(3);
    localparam logic [ALUOP_WIDTH-1:0] OP_SLT = ALUOP_WIDTH'(4);
    localparam logic [ALUOP_WIDTH-1:0] OP_SLL = ALUOP_WIDTH'(5);
    localparam logic [ALUOP_WIDTH-1:0] OP_SRL = ALUOP_WIDTH'(6);
    localparam logic [ALUOP_WIDTH-1:0] OP_LUI = ALUOP_WIDTH'(7);

    state_t state;

    logic                   is_r, r_ok, r_shift;
    logic [ALUOP_WIDTH-1:0] r_aop;
    logic                   is_addi, is_andi, is_ori, is_lui, is_lw, is_sw;
    logic                   is_beq, is_bne, is_j, i_alu, supported;

    // Instruction class decode straight from the IR fields
    always_comb begin
        r_ok    = 1'b1;
        r_shift = 1'b0;
        r_aop   = OP_ADD;
        case (funct)
            6'h20:   r_aop = OP_ADD;
            6'h22:   r_aop = OP_SUB;
            6'h24:   r_aop = OP_AND;
            6'h25:   r_aop = OP_OR;
            6'h2A:   r_aop = OP_SLT;
            6'h00:   begin r_aop = OP_SLL; r_shift = 1'b1; end
            6'h02:   begin r_aop = OP_SRL; r_shift = 1'b1; end
            default: r_ok = 1'b0;
        endcase
        is_r    = (opcode == 6'h00);
        is_addi = (opcode == 6'h08);
        is_andi = (opcode == 6'h0C);
        is_ori  = (opcode == 6'h0D);
        is_lui  = (opcode == 6'h0F);
        is_lw   = (opcode == 6'h23);
        is_sw   = (opcode == 6'h2B);
        is_beq  = (opcode == 6'h04);
        is_bne  = (opcode == 6'h05);
`ifdef MIPS_CTRL_JUMP_EN
        is_j    = (opcode == 6'h02);
`else
        is_j    = 1'b0;
`endif
        i_alu     = is_addi | is_andi | is_ori | is_lui;
        supported = (is_r & r_ok) | i_alu | is_lw | is_sw | is_beq | is_bne | is_j;
    end

    // State sequencing; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:     state <= FETCH;
                FETCH:    state <= DECODE;
                DECODE:   state <= supported ? EXEC : FETCH;
                EXEC:     state <= is_j ? FETCH : WB;
                WB:       state <= is_sw ? ST_DUMMY : FETCH;
                ST_DUMMY: state <= FETCH;
                default:  state <= IDLE;
            endcase
        end
    end

    // Outputs decoded from state alone (plus the IR fields it holds). They are
    // not flopped: the branch PC write must follow the same-cycle zero flag and
    // illegal_op depends on the IR loaded on the edge entering DECODE.
    // Because IDLE decodes to all-zero, async reset clears every strobe at once.
    always_comb begin
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 3'd0;
        alu_op     = OP_ADD;
        alu_out_we = 1'b0;
        pc_src     = 2'd0;
        illegal_op = 1'b0;
        case (state)
            FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 3'd1;
            end
            DECODE: begin
                alu_src_b  = 3'd4;
                alu_out_we = 1'b1;
                illegal_op = ~supported;
            end
            EXEC: begin
                if (is_r) begin
                    alu_src_a  = r_shift ? 2'd2 : 2'd1;
                    alu_op     = r_aop;
                    alu_out_we = 1'b1;
                end else if (is_beq | is_bne) begin
                    alu_src_a = 2'd1;
                    alu_op    = OP_SUB;
                    pc_src    = 2'd1;
                    pc_write  = is_beq ? zero : ~zero;
                end else if (is_j) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                end else begin
                    alu_src_a  = 2'd1;
                    alu_out_we = 1'b1;
                    alu_src_b  = (is_andi | is_ori | is_lui) ? 3'd3 : 3'd2;
                    if (is_andi)     alu_op = OP_AND;
                    else if (is_ori) alu_op = OP_OR;
                    else if (is_lui) alu_op = OP_LUI;
                end
            end
            WB: begin
                if (is_r) begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end else if (i_alu) begin
                    reg_write = 1'b1;
                end else if (is_lw) begin
                    iord       = 1'b1;
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end else if (is_sw) begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
            end
            ST_DUMMY: iord = 1'b1;
            default: ;
        endcase
    end

    assign count_state = state;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: per-cycle expected output vectors are
// queued as each instruction is driven and popped on every falling edge.
module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero;
    logic       pc_write, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic [1:0] alu_src_a, pc_src;
    logic [2:0] alu_src_b;
    logic [3:0] alu_op, count_state;
    logic       alu_out_we, illegal_op;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, iord, memw, irw, rdst, m2r, regw;
        logic [1:0] asa;
        logic [2:0] asb;
        logic [3:0] aop;
        logic       aowe;
        logic [1:0] pcsrc;
        logic       ill;
    } obs_t;

    obs_t    obs;
    obs_t    q[$];
    int      checks = 0;
    int      errors = 0;
    obs_t    FE, Z, EX_ADDI, WB_I, WB_R;

    mips_mc_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_write(pc_write), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .alu_out_we(alu_out_we), .pc_src(pc_src), .illegal_op(illegal_op),
        .count_state(count_state)
    );

    always #5 clk = ~clk;

    always_comb obs = {count_state, pc_write, iord, mem_write, ir_write, reg_dst,
                       mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                       alu_out_we, pc_src, illegal_op};

    function automatic obs_t mk(input int st, pcw, io, mw, irw, rd, m2r, rw,
                                input int asa, asb, aop, aowe, ps, ill);
        obs_t o;
        o.st = 4'(st); o.pcw = 1'(pcw); o.iord = 1'(io); o.memw = 1'(mw);
        o.irw = 1'(irw); o.rdst = 1'(rd); o.m2r = 1'(m2r); o.regw = 1'(rw);
        o.asa = 2'(asa); o.asb = 3'(asb); o.aop = 4'(aop); o.aowe = 1'(aowe);
        o.pcsrc = 2'(ps); o.ill = 1'(ill);
        return o;
    endfunction

    function automatic obs_t de(input int ill);
        return mk(2, 0,0,0,0,0,0,0, 0,4,0,1,0, ill);
    endfunction

    task automatic compare_now(input string tag);
        obs_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed=%h", tag, obs);
            return;
        end
        e = q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        compare_now(tag);
    endtask

    // One instruction: FETCH check, then load IR fields and check n more states
    task automatic run(input string tag, input logic [31:0] ir, input logic z,
                       input int n, input obs_t e0, e1, e2, e3);
        q.push_back(FE);
        step({tag, "/fetch"});
        opcode = ir[31:26];
        funct  = ir[5:0];
        zero   = z;
        q.push_back(e0);
        if (n > 1) q.push_back(e1);
        if (n > 2) q.push_back(e2);
        if (n > 3) q.push_back(e3);
        for (int i = 0; i < n; i++) step($sformatf("%s/s%0d", tag, i + 2));
    endtask

    initial begin
        FE      = mk(1, 1,0,0,1,0,0,0, 0,1,0,0,0, 0);
        Z       = '0;
        EX_ADDI = mk(3, 0,0,0,0,0,0,0, 1,2,0,1,0, 0);
        WB_I    = mk(4, 0,0,0,0,0,0,1, 0,0,0,0,0, 0);
        WB_R    = mk(4, 0,0,0,0,1,0,1, 0,0,0,0,0, 0);

        reset = 1'b0; opcode = 6'h3F; funct = 6'h3F; zero = 1'b1;
        #1;
        q.push_back(Z);
        compare_now("reset_idle");
        @(negedge clk);
        q.push_back(Z);
        compare_now("reset_hold");
        reset = 1'b1;

        run("addi", 32'h21080003, 1'b1, 3, de(0), EX_ADDI, WB_I, Z);
        run("add",  32'h01288820, 1'b0, 3, de(0), mk(3, 0,0,0,0,0,0,0, 1,0,0,1,0, 0), WB_R, Z);
        run("sll",  32'h00118880, 1'b0, 3, de(0), mk(3, 0,0,0,0,0,0,0, 2,0,5,1,0, 0), WB_R, Z);
        run("srl",  32'h00118882, 1'b0, 3, de(0), mk(3, 0,0,0,0,0,0,0, 2,0,6,1,0, 0), WB_R, Z);
        run("slt",  32'h0128882A, 1'b0, 3, de(0), mk(3, 0,0,0,0,0,0,0, 1,0,4,1,0, 0), WB_R, Z);
        run("sw",   32'had910000, 1'b0, 4, de(0), EX_ADDI,
            mk(4, 0,1,1,0,0,0,0, 0,0,0,0,0, 0), mk(5, 0,1,0,0,0,0,0, 0,0,0,0,0, 0));
        run("lw",   32'h8d940000, 1'b0, 3, de(0), EX_ADDI,
            mk(4, 0,1,0,0,0,1,1, 0,0,0,0,0, 0), Z);
        run("andi", 32'h3108000F, 1'b0, 3, de(0), mk(3, 0,0,0,0,0,0,0, 1,3,2,1,0, 0), WB_I, Z);
        run("ori",  32'h3508000F, 1'b0, 3, de(0), mk(3, 0,0,0,0,0,0,0, 1,3,3,1,0, 0), WB_I, Z);
        run("lui",  32'h3C081234, 1'b0, 3, de(0), mk(3, 0,0,0,0,0,0,0, 1,3,7,1,0, 0), WB_I, Z);
        run("beq_taken", 32'h11090002, 1'b1, 3, de(0),
            mk(3, 1,0,0,0,0,0,0, 1,0,1,0,1, 0), mk(4, 0,0,0,0,0,0,0, 0,0,0,0,0, 0), Z);
        run("beq_not",   32'h11090002, 1'b0, 3, de(0),
            mk(3, 0,0,0,0,0,0,0, 1,0,1,0,1, 0), mk(4, 0,0,0,0,0,0,0, 0,0,0,0,0, 0), Z);
        run("bne_taken", 32'h15090002, 1'b0, 3, de(0),
            mk(3, 1,0,0,0,0,0,0, 1,0,1,0,1, 0), mk(4, 0,0,0,0,0,0,0, 0,0,0,0,0, 0), Z);
        run("bne_not",   32'h15090002, 1'b1, 3, de(0),
            mk(3, 0,0,0,0,0,0,0, 1,0,1,0,1, 0), mk(4, 0,0,0,0,0,0,0, 0,0,0,0,0, 0), Z);
        run("illegal_op3f",  32'hFC000000, 1'b0, 1, de(1), Z, Z, Z);
        run("illegal_funct", 32'h01288821, 1'b0, 1, de(1), Z, Z, Z);
`ifdef MIPS_CTRL_JUMP_EN
        run("jump", 32'h08000010, 1'b0, 2, de(0), mk(3, 1,0,0,0,0,0,0, 0,0,0,0,2, 0), Z, Z);
`else
        run("jump_illegal", 32'h08000010, 1'b0, 1, de(1), Z, Z, Z);
`endif

        // Reset asserted mid-EXEC, away from any clock edge
        q.push_back(FE);
        step("midrst/fetch");
        opcode = 6'h08; funct = 6'h03; zero = 1'b0;
        q.push_back(de(0));
        q.push_back(EX_ADDI);
        step("midrst/decode");
        step("midrst/exec");
        #2 reset = 1'b0;
        #1;
        q.push_back(Z);
        compare_now("midrst/async_clear");
        @(negedge clk);
        q.push_back(Z);
        compare_now("midrst/held");
        reset = 1'b1;

        run("addi_after_reset", 32'h21080003, 1'b0, 3, de(0), EX_ADDI, WB_I, Z);
        q.push_back(FE);
        step("final_fetch");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
